and_gate_sequencer: RTL and testbench

- Self-checking stimulus controller for a 2-input AND gate (`better_and_gate`). It drives the gate's `a` and `b` through a fixed 9-step pattern and holds each step for a programmable dwell time.
- At the end of each dwell it compares the gate's `out` against `a & b`, counts mismatches and reports pass/fail.
- Sits between a simple start/status interface and the gate under test. This lets gate checks run as synthesizable hardware instead of a hand-written `#10` delay sequence.

---
 rtl/and_gate_sequencer_if.sv | 22 ++
 rtl/and_gate_sequencer.sv | 122 ++++++++++++
 tb/tb_and_gate_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/and_gate_sequencer_if.sv
// Start/status handshake plus the drive/observe lines of the AND gate under test.
interface and_gate_sequencer_if;
    logic       start;
    logic       dut_out;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [3:0] step_idx;

    modport master (
        output start, dut_out,
        input  a, b, busy, done, pass, err_count, step_idx
    );

    modport slave (
        input  start, dut_out,
        output a, b, busy, done, pass, err_count, step_idx
    );
endinterface

// File: rtl/and_gate_sequencer.sv
// Drives a 2-input AND gate through a fixed 9-step pattern, holding each step
// for DWELL_CYCLES clocks and checking the gate output on the last cycle of each step.
module and_gate_sequencer #(
    parameter int unsigned DWELL_CYCLES = 10,
    parameter int unsigned DW_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and_gate_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DW_W-1:0] LAST_DWELL = DW_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]      LAST_STEP  = 4'd8;

    state_t          state, state_nx;
    logic            a_q, a_nx;
    logic            b_q, b_nx;
    logic            busy_q, busy_nx;
    logic            done_q, done_nx;
    logic            pass_q, pass_nx;
    logic [3:0]      err_q, err_nx;
    logic [3:0]      step_q, step_nx;
    logic [DW_W-1:0] dwell_q, dwell_nx;
    logic [3:0]      err_sum;
    logic [1:0]      pat_next;

    function automatic logic [1:0] pattern(input logic [3:0] idx);
        logic [1:0] ab;
        case (idx)
            4'd1:    ab = 2'b10;
            4'd2:    ab = 2'b11;
            4'd3:    ab = 2'b01;
            4'd5:    ab = 2'b10;
            4'd6:    ab = 2'b10;
            4'd8:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            pass_q  <= pass_nx;
            err_q   <= err_nx;
            step_q  <= step_nx;
            dwell_q <= dwell_nx;
        end
    end

    // The sum includes this step's comparison so pass reflects the final count.
    assign err_sum  = err_q + 4'((bus.dut_out != (a_q & b_q)) ? 1 : 0);
    assign pat_next = pattern(step_q + 4'd1);

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        busy_nx  = busy_q;
        done_nx  = done_q;
        pass_nx  = pass_q;
        err_nx   = err_q;
        step_nx  = step_q;
        dwell_nx = dwell_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx    = RUN;
                    {a_nx, b_nx} = pattern(4'd0);
                    busy_nx     = 1'b1;
                    done_nx     = 1'b0;
                    pass_nx     = 1'b0;
                    err_nx      = '0;
                    step_nx     = '0;
                    dwell_nx    = '0;
                end
            end
            RUN: begin
                dwell_nx = dwell_q + DW_W'(1);
                if (dwell_q == LAST_DWELL) begin
                    err_nx   = err_sum;
                    dwell_nx = '0;
                    if (step_q < LAST_STEP) begin
                        step_nx      = step_q + 4'd1;
                        {a_nx, b_nx} = pat_next;
                    end else begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_sum == 4'd0);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.step_idx  = step_q;

endmodule

// File: tb/tb_and_gate_sequencer.sv
// Directed bench for and_gate_sequencer: correct, stuck-at-0 and stuck-at-1 gates,
// mid-run reset, restart rules, held start, and a short-dwell instance with a lagging gate.
module tb_and_gate_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   mode;          // 0: correct gate, 1: out stuck 0, 2: out stuck 1
    logic d1;

    // Step pattern, bit k = value at step k
    logic [8:0] pa;
    logic [8:0] pb;

    and_gate_sequencer_if if0 ();
    and_gate_sequencer_if if1 ();

    and_gate_sequencer #(.DWELL_CYCLES(10), .DW_W(16)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    and_gate_sequencer #(.DWELL_CYCLES(2), .DW_W(4)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if0.dut_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (if0.a & if0.b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) d1 <= 1'b0;
        else        d1 <= if1.a & if1.b;
    end
    assign if1.dut_out = d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] status0();
        return {if0.busy, if0.done, if0.pass, if0.err_count, if0.step_idx, if0.a, if0.b};
    endfunction

    // Full 90-cycle run on u0; pulse_at >= 0 re-asserts start for one cycle mid-run.
    task automatic run_seq(input int m, input int pulse_at);
        int         e;
        int         k;
        logic       gate;
        logic [3:0] e4;
        logic [3:0] k4;
        mode = m;
        e = 0;
        if0.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 90; i++) begin
            k = i / 10;
            if0.start = (i == pulse_at);
            e4 = 4'(e);
            k4 = 4'(k);
            chk("run", 32'(status0()), 32'({1'b1, 1'b0, 1'b0, e4, k4, pa[k], pb[k]}));
            if (i % 10 == 9) begin
                gate = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (pa[k] & pb[k]);
                if (gate != (pa[k] & pb[k])) e++;
            end
            @(negedge clk);
        end
        if0.start = 1'b0;
        e4 = 4'(e);
        chk("end", 32'(status0()), 32'({1'b0, 1'b1, (e == 0), e4, 4'd8, pa[8], pb[8]}));
    endtask

    initial begin
        int cnt;
        total = 0;
        bad   = 0;
        mode  = 0;
        pa    = 9'b001100110;
        pb    = 9'b100001100;
        if0.start = 1'b0;
        if1.start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset0", 32'(status0()), 32'd0);
        chk("reset1", 32'({if1.busy, if1.done, if1.pass, if1.err_count, if1.step_idx, if1.a, if1.b}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'(status0()), 32'd0);

        run_seq(0, -1);
        chk("good_err", 32'(if0.err_count), 32'd0);
        chk("good_pass", 32'(if0.pass), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(status0()), 32'({1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b1}));

        run_seq(1, -1);
        chk("stuck0_err", 32'(if0.err_count), 32'd1);
        run_seq(2, -1);
        chk("stuck1_err", 32'(if0.err_count), 32'd8);
        run_seq(0, 35);
        chk("midstart_pass", 32'(if0.pass), 32'd1);

        // Asynchronous reset during step 4 of a failing run
        mode = 1;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (45) @(negedge clk);
        chk("pre_rst", 32'({if0.err_count, if0.step_idx}), 32'({4'd1, 4'd4}));
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(status0()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(0, -1);

        // start held high: runs back to back, done high for one cycle
        if0.start = 1'b1;
        @(negedge clk);
        chk("hold_busy", 32'(if0.busy), 32'd1);
        cnt = 0;
        while (!if0.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_lat", 32'(cnt), 32'd90);
        @(negedge clk);
        chk("hold_restart", 32'({if0.busy, if0.done, if0.step_idx}), 32'({1'b1, 1'b0, 4'd0}));
        if0.start = 1'b0;
        cnt = 0;
        while (!if0.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_done2", 32'(if0.done), 32'd1);

        // Two-cycle dwell with gate output lagging one cycle
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            chk("d2_run", 32'({if1.busy, if1.done, if1.err_count, if1.step_idx, if1.a, if1.b}),
                32'({1'b1, 1'b0, 4'd0, 4'(i / 2), pa[i / 2], pb[i / 2]}));
            @(negedge clk);
        end
        chk("d2_end", 32'({if1.busy, if1.done, if1.pass, if1.err_count}), 32'({1'b0, 1'b1, 1'b1, 4'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
